// File: rtl/btn_debounce_pkg.sv
// Shared constants for the console button debouncer: default IO offsets,
// idle pin level and stability-counter width derivation.
package btn_debounce_pkg;

  localparam logic [7:0] EVT_ADDR_DEF  = 8'h23;
  localparam logic [7:0] MASK_ADDR_DEF = 8'h24;
  localparam logic [7:0] REL_ADDR_DEF  = 8'h25;

  localparam logic [7:0] BTN_IDLE = 8'hFF;

  localparam int CNT_W = 4;

  // Four bits cover every legal STABLE_TICKS; wider only if someone stretches the range.
  function automatic int cntWidth(input int stableTicks);
    return (stableTicks <= 15) ? CNT_W : $clog2(stableTicks + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One debounce cell: accepts a new level after STABLE_TICKS consecutive
// differing samples, and flags the accepting cycle as a fall or rise.
module btn_debounce_cell
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sample_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CW = cntWidth(STABLE_TICKS);

  logic [CW-1:0] cnt_q, cnt_d, cntInc;
  logic          level_q, level_d;
  logic          accept;

  // Any sample agreeing with the current level restarts the stability count.
  always_comb begin
    cntInc  = cnt_q + CW'(1);
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (tick_i) begin
      if (sample_i == level_q) begin
        cnt_d = '0;
      end else if (cntInc == CW'(STABLE_TICKS)) begin
        accept  = 1'b1;
        level_d = sample_i;
        cnt_d   = '0;
      end else begin
        cnt_d = cntInc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = accept & ~sample_i;
  assign rise_o  = accept & sample_i;

endmodule

// File: rtl/btn_debounce.sv
// Console button debouncer with press-event flags, interrupt mask and intr/ack handshake.
// Define BTN_DEBOUNCE_RELEASE_EVT_EN to add release-event flags at REL_ADDR.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int         WIDTH        = 8,
  parameter int         PRESCALE     = 16000,
  parameter int         PRESCALE_W   = 14,
  parameter int         STABLE_TICKS = 8,
  parameter logic [7:0] EVT_ADDR     = EVT_ADDR_DEF,
  parameter logic [7:0] MASK_ADDR    = MASK_ADDR_DEF,
  parameter logic [7:0] REL_ADDR     = REL_ADDR_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o,
  input  logic [7:0]       addr_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [7:0]       bus_i,
  output logic [7:0]       bus_o,
  output logic             intr_o,
  input  logic             int_ack_i
);

  logic [WIDTH-1:0]      sync1_q, sync2_q;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick;
  logic [WIDTH-1:0]      fall, rise;
  logic [WIDTH-1:0]      evt_q, evt_d, mask_q, mask_d;
  logic [WIDTH-1:0]      wrData, ackClr;
  logic                  evtWr, maskWr;
  logic                  intr_q, intr_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= BTN_IDLE[WIDTH-1:0];
      sync2_q <= BTN_IDLE[WIDTH-1:0];
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign tick    = (presc_q == PRESCALE_W'(PRESCALE - 1));
  assign presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    btn_debounce_cell #(.STABLE_TICKS(STABLE_TICKS)) uCell (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick),
      .sample_i (sync2_q[i]),
      .level_o  (btn_o[i]),
      .fall_o   (fall[i]),
      .rise_o   (rise[i])
    );
  end

  assign wrData = bus_i[WIDTH-1:0];
  assign evtWr  = wr_i && (addr_i == EVT_ADDR);
  assign maskWr = wr_i && (addr_i == MASK_ADDR);
  assign ackClr = int_ack_i ? mask_q : '0;

  // Fresh edges are ORed in after the clear so a same-cycle set always survives.
  assign evt_d  = (evt_q & ~((evtWr ? wrData : '0) | ackClr)) | fall;
  assign mask_d = maskWr ? wrData : mask_q;

`ifdef BTN_DEBOUNCE_RELEASE_EVT_EN
  logic [WIDTH-1:0] rel_q, rel_d;
  logic             relWr;

  assign relWr  = wr_i && (addr_i == REL_ADDR);
  assign rel_d  = (rel_q & ~((relWr ? wrData : '0) | ackClr)) | rise;
  assign intr_d = |((evt_q | rel_q) & mask_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rel_q <= '0;
    else        rel_q <= rel_d;
  end
`else
  logic unusedRel;
  assign unusedRel = ^{rise, REL_ADDR};
  assign intr_d    = |(evt_q & mask_q);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      evt_q  <= '0;
      mask_q <= '0;
      intr_q <= 1'b0;
    end else begin
      evt_q  <= evt_d;
      mask_q <= mask_d;
      intr_q <= intr_d;
    end
  end

  assign intr_o = intr_q;

  // Unselected reads drive zero so this can be ORed straight into the io_in mux.
  always_comb begin
    bus_o = 8'h00;
    if (rd_i) begin
      if (addr_i == EVT_ADDR)       bus_o = 8'(evt_q);
      else if (addr_i == MASK_ADDR) bus_o = 8'(mask_q);
`ifdef BTN_DEBOUNCE_RELEASE_EVT_EN
      else if (addr_i == REL_ADDR)  bus_o = 8'(rel_q);
`endif
    end
  end

endmodule
